router_fifo: RTL

- Per-destination packet FIFO of the 1x3 router; three instances, one per output port.
- Sits downstream of the synchronizer: takes its one-hot write enable bit and per-port soft reset; returns full/empty, from which the synchronizer derives fifo_full and valid.
- Stores header-tagged bytes and tracks packet length on the read side.
- Clears the output bus once a packet is fully drained.

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_fifo.sv | 82 ++++++++
 2 files changed

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: data width, FIFO depth, header field layout.
// Also provides the helper that converts a header length field into a read count.
package router_pkg;

  localparam int ROUTER_DATA_W     = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 2;
  localparam int LEN_LSB  = 2;
  localparam int LEN_W    = 6;

  localparam int HDR_TAG_BIT = ROUTER_DATA_W;
  localparam int PKT_CNT_W   = 7;

  // Bytes that follow a header: payload length plus the parity byte.
  function automatic logic [PKT_CNT_W-1:0] hdr_count(input logic [LEN_W-1:0] len);
    return PKT_CNT_W'(len) + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-destination packet FIFO: header-tagged storage, read-side packet length tracking.
// Define ROUTER_FIFO_OCCUPANCY_EN to add the fill_level output.
module router_fifo
  import router_pkg::*;
#(
  parameter int DATA_W = ROUTER_DATA_W,
  parameter int DEPTH  = ROUTER_FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
`ifdef ROUTER_FIFO_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH):0] fill_level
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W:0]        mem [DEPTH];
  logic [AW:0]            wr_ptr_reg;
  logic [AW:0]            rd_ptr_reg;
  logic [PKT_CNT_W-1:0]   pkt_cnt_reg;
  logic [DATA_W-1:0]      data_out_reg;
  logic [DATA_W:0]        rd_word;
  logic                   clear;
  logic                   wr_accept;
  logic                   rd_accept;

  assign clear     = !resetn || soft_reset;
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  // Requests arriving during a reset/flush cycle are discarded.
  assign wr_accept = write_enb && !full && !clear;
  assign rd_accept = read_enb && !empty && !clear;
  assign rd_word   = mem[rd_ptr_reg[AW-1:0]];
  assign data_out  = data_out_reg;

`ifdef ROUTER_FIFO_OCCUPANCY_EN
  assign fill_level = wr_ptr_reg - rd_ptr_reg;
`endif

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_ptr_reg[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      pkt_cnt_reg  <= '0;
      data_out_reg <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (rd_accept) begin
        rd_ptr_reg   <= rd_ptr_reg + (AW+1)'(1);
        data_out_reg <= rd_word[DATA_W-1:0];
        if (rd_word[DATA_W]) begin
          pkt_cnt_reg <= hdr_count(rd_word[LEN_LSB +: LEN_W]);
        end else if (pkt_cnt_reg != '0) begin
          pkt_cnt_reg <= pkt_cnt_reg - PKT_CNT_W'(1);
        end
      end else if (pkt_cnt_reg == '0) begin
        data_out_reg <= '0;
      end
    end
  end

endmodule
